prim_subreg_mhw: RTL

- Parametrised, stateful register-field primitive for the register-file generator: storage flop plus SW/HW write arbitration in one block.
- Extends single-writer arbitration with NHW prioritised hardware write channels, an optional shadowed (double-write) SW commit, a registered SW-update strobe, and sticky collision/shadow-error status.
- Instantiated once per field inside generated register blocks.

---
 rtl/prim_subreg_mhw.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/prim_subreg_mhw.sv
// Register-field primitive: storage flop with SW/multi-channel HW write arbitration,
// optional shadowed (double-write) SW commit, registered SW-update strobe and sticky status.
module prim_subreg_mhw #(
    parameter int              DW       = 32,
    parameter int              NHW      = 2,
    parameter string           SWACCESS = "RW",
    parameter logic [DW-1:0]   RESVAL   = '0,
    parameter bit              SHADOW   = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we,
    input  logic [DW-1:0]      wd,
    input  logic               re,
    input  logic [NHW-1:0]     de,
    input  logic [NHW*DW-1:0]  d,
    input  logic               err_clr_i,
    input  logic               coll_clr_i,
    output logic [DW-1:0]      q,
    output logic [DW-1:0]      qs,
    output logic               qe,
    output logic               staged_o,
    output logic               shadow_err_o,
    output logic               collision_o
);

    localparam bit IS_RW  = (SWACCESS == "RW");
    localparam bit IS_RO  = (SWACCESS == "RO");
    localparam bit IS_WO  = (SWACCESS == "WO");
    localparam bit IS_W1C = (SWACCESS == "W1C");
    localparam bit IS_W1S = (SWACCESS == "W1S");
    localparam bit IS_W0C = (SWACCESS == "W0C");
    localparam bit IS_RC  = (SWACCESS == "RC");

    if (!(IS_RW || IS_RO || IS_WO || IS_W1C || IS_W1S || IS_W0C || IS_RC)) begin : gen_bad_access
        $error("prim_subreg_mhw: unsupported SWACCESS %s", SWACCESS);
    end
    if (SHADOW && !(IS_RW || IS_WO)) begin : gen_bad_shadow
        $error("prim_subreg_mhw: SHADOW requires RW or WO access, got %s", SWACCESS);
    end

    typedef enum logic {IDLE, STAGED} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     stage_q, stage_d;
    logic              commit, mismatch;
    logic              hw_de, multi_de, sw_we;
    logic [DW-1:0]     hw_d, base, next_q;
    logic [NHW-1:0]    de_m1;

    // Lowest-index asserted channel wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        hw_d = '0;
        for (int k = NHW - 1; k >= 0; k--) begin
            if (de[k]) begin
                hw_d = d[k*DW +: DW];
            end
        end
    end

    assign hw_de    = |de;
    assign de_m1    = de - NHW'(1);
    assign multi_de = |(de & de_m1);

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        commit   = 1'b0;
        mismatch = 1'b0;
        if (SHADOW) begin
            case (state_q)
                IDLE: begin
                    if (we) begin
                        stage_d = wd;
                        state_d = STAGED;
                    end
                end
                STAGED: begin
                    if (we) begin
                        commit   = (wd == stage_q);
                        mismatch = (wd != stage_q);
                        stage_d  = '0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    assign sw_we = IS_RC  ? re :
                   IS_RO  ? 1'b0 :
                   SHADOW ? commit : we;

    assign base = hw_de ? hw_d : q;

    always_comb begin
        next_q = base;
        if (IS_RW || IS_WO) begin
            next_q = sw_we ? wd : base;
        end else if (IS_W1S) begin
            next_q = base | (sw_we ? wd : '0);
        end else if (IS_W1C) begin
            next_q = base & (sw_we ? ~wd : '1);
        end else if (IS_W0C) begin
            next_q = base & (sw_we ? wd : '1);
        end else if (IS_RC) begin
            next_q = sw_we ? '0 : base;
        end
    end

    // Sticky status flags: a set in the same cycle as its clear takes precedence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q            <= RESVAL;
            qe           <= 1'b0;
            shadow_err_o <= 1'b0;
            collision_o  <= 1'b0;
        end else begin
            if (sw_we || hw_de) begin
                q <= next_q;
            end
            qe           <= sw_we;
            shadow_err_o <= mismatch | (shadow_err_o & ~err_clr_i);
            collision_o  <= (sw_we & hw_de) | multi_de | (collision_o & ~coll_clr_i);
        end
    end

    assign qs       = q;
    assign staged_o = (state_q == STAGED);

endmodule
